// File: rtl/dcache_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dcache_port_arbiter_pkg
//   Shared types for the data-cache port arbiter: address/data aliases, the
//   arbiter state encoding, the grant-owner encoding and the width of the
//   load-starvation counter.
// ---------------------------------------------------------------------------
package dcache_port_arbiter_pkg;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] uint32_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LOAD_WAIT,
    ARB_STORE_WAIT
  } Arb_State_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_LOAD,
    OWN_STORE
  } arb_owner_t;

  localparam int unsigned STARVE_CNT_W = 4;
  localparam logic [STARVE_CNT_W-1:0] STARVE_CNT_MAX = '1;

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dcache_port_arbiter_if
//   Bundles the three parties around the arbiter: the AGU load port (ld_*),
//   the store-buffer commit port (st_*) and the single DBus dcache port
//   (dcache_*).
//   modport slave  : the arbiter's view (takes requests, drives the dcache).
//   modport master : the surrounding pipeline/dcache view (mirror image).
// ---------------------------------------------------------------------------
interface dcache_port_arbiter_if;
  import dcache_port_arbiter_pkg::*;

  // Load path
  logic        ld_req;
  logic [2:0]  ld_size;
  virt_t       ld_addr;
  logic        ld_addr_ok;
  logic        ld_data_ok;
  uint32_t     ld_rdata;

  // Store commit path
  logic        st_req;
  logic [3:0]  st_wstrb;
  logic [2:0]  st_size;
  virt_t       st_addr;
  uint32_t     st_wdata;
  logic        st_addr_ok;
  logic        st_data_ok;

  // DBus dcache port
  logic        dcache_req;
  logic        dcache_wr;
  logic [3:0]  dcache_wstrb;
  logic [2:0]  dcache_size;
  virt_t       dcache_addr;
  uint32_t     dcache_wdata;
  logic        dcache_addr_ok;
  logic        dcache_data_ok;
  uint32_t     dcache_rdata;

  modport slave (
    input  ld_req, ld_size, ld_addr,
    output ld_addr_ok, ld_data_ok, ld_rdata,
    input  st_req, st_wstrb, st_size, st_addr, st_wdata,
    output st_addr_ok, st_data_ok,
    output dcache_req, dcache_wr, dcache_wstrb, dcache_size, dcache_addr, dcache_wdata,
    input  dcache_addr_ok, dcache_data_ok, dcache_rdata
  );

  modport master (
    output ld_req, ld_size, ld_addr,
    input  ld_addr_ok, ld_data_ok, ld_rdata,
    output st_req, st_wstrb, st_size, st_addr, st_wdata,
    input  st_addr_ok, st_data_ok,
    input  dcache_req, dcache_wr, dcache_wstrb, dcache_size, dcache_addr, dcache_wdata,
    output dcache_addr_ok, dcache_data_ok, dcache_rdata
  );

endinterface

// File: rtl/dcache_port_arbiter.sv
// ---------------------------------------------------------------------------
// dcache_port_arbiter
//   Shares the single dcache port between the AGU load path and the store
//   buffer commit path. One transaction is outstanding at a time; a grant
//   stays locked until its address handshake, and data_ok is routed back to
//   whichever side owns the outstanding transaction. Loads cancelled by a
//   pipeline flush have their response absorbed. Stores win contention, but
//   after STARVE_LIMIT store grants with a load waiting, one load is forced.
//
//   Ports:
//     clk    clock
//     reset  asynchronous, active-high
//     flush  pipeline flush (cancels load traffic only)
//     bus    dcache_port_arbiter_if.slave: ld_*, st_* and dcache_* signals
// ---------------------------------------------------------------------------
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  dcache_port_arbiter_if.slave  bus
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  Arb_State_t              state_q, state_d;
  arb_owner_t              lock_owner_q, lock_owner_d;
  logic                    cancel_q, cancel_d;
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  arb_owner_t sel;
  logic       force_ld;
  logic       pick_store;
  logic       hs;
  logic       ld_hs;
  logic       st_hs;

  // Requester selection; only meaningful while no transaction is outstanding.
  always_comb begin
    force_ld = (starve_cnt_q == LIMIT) && bus.ld_req;
    sel      = OWN_NONE;
    if (state_q == ARB_IDLE) begin
      case (lock_owner_q)
        OWN_STORE: sel = OWN_STORE;
        // A flush abandons a locked load; the request drops this same cycle.
        OWN_LOAD:  sel = flush ? OWN_NONE : OWN_LOAD;
        default: begin
          if (bus.st_req && !force_ld)    sel = OWN_STORE;
          else if (bus.ld_req && !flush)  sel = OWN_LOAD;
        end
      endcase
    end
  end

  // Payload follows the store side whenever it is the candidate, so an
  // un-granted cycle still shows a stable store address.
  assign pick_store = (sel == OWN_STORE) || ((sel == OWN_NONE) && bus.st_req);

  // The request is gated by reset so every handshake output is quiet while
  // reset is held, even if the requesters keep their lines high.
  assign bus.dcache_req   = !reset && (sel != OWN_NONE);
  assign bus.dcache_wr    = pick_store;
  assign bus.dcache_wstrb = pick_store ? bus.st_wstrb : 4'b0000;
  assign bus.dcache_size  = pick_store ? bus.st_size  : bus.ld_size;
  assign bus.dcache_addr  = pick_store ? bus.st_addr  : bus.ld_addr;
  assign bus.dcache_wdata = pick_store ? bus.st_wdata : 32'h0;

  assign hs    = bus.dcache_req && bus.dcache_addr_ok;
  assign ld_hs = hs && (sel == OWN_LOAD);
  assign st_hs = hs && (sel == OWN_STORE);

  assign bus.ld_addr_ok = ld_hs;
  assign bus.st_addr_ok = st_hs;
  assign bus.ld_data_ok = (state_q == ARB_LOAD_WAIT) && bus.dcache_data_ok && !cancel_q;
  assign bus.st_data_ok = (state_q == ARB_STORE_WAIT) && bus.dcache_data_ok;
  assign bus.ld_rdata   = bus.dcache_rdata;

  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    cancel_d     = cancel_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      ARB_IDLE: begin
        // Hold the grant across address-phase stalls.
        lock_owner_d = (bus.dcache_req && !bus.dcache_addr_ok) ? sel : OWN_NONE;
        if (st_hs) begin
          state_d = ARB_STORE_WAIT;
        end else if (ld_hs) begin
          state_d  = ARB_LOAD_WAIT;
          cancel_d = flush;
        end
      end
      ARB_LOAD_WAIT: begin
        // data_ok wins over a simultaneous flush: the data is delivered.
        if (bus.dcache_data_ok) begin
          state_d  = ARB_IDLE;
          cancel_d = 1'b0;
        end else if (flush) begin
          cancel_d = 1'b1;
        end
      end
      ARB_STORE_WAIT: begin
        if (bus.dcache_data_ok) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (!bus.ld_req || ld_hs) begin
      starve_cnt_d = '0;
    end else if (st_hs && (starve_cnt_q != STARVE_CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      lock_owner_q <= OWN_NONE;
      cancel_q     <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      cancel_q     <= cancel_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;
  import dcache_port_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  dcache_port_arbiter_if bus();

  dcache_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {dcache_req, ld_addr_ok, st_addr_ok, ld_data_ok, st_data_ok}
  task automatic ok5(input string name, input logic [4:0] exp);
    chk(name, {27'b0, bus.dcache_req, bus.ld_addr_ok, bus.st_addr_ok,
               bus.ld_data_ok, bus.st_data_ok}, {27'b0, exp});
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    bus.ld_req = 1'b0; bus.ld_size = 3'd2; bus.ld_addr = 32'h0000_1000;
    bus.st_req = 1'b0; bus.st_wstrb = 4'hF; bus.st_size = 3'd2;
    bus.st_addr = 32'h0000_2000; bus.st_wdata = 32'hCAFE_F00D;
    bus.dcache_addr_ok = 1'b0; bus.dcache_data_ok = 1'b0; bus.dcache_rdata = 32'h0;
  endtask

  // Leaves the caller at a falling edge with reset released.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic        ld, st, fl, aok;
    logic [4:0]  exp_ok;
    logic        exp_wr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vt[8];

  // Behavioural reference state: who owns the outstanding transaction
  // (0 none, 1 load, 2 store), who holds a stalled grant, whether the
  // outstanding load was cancelled, and stores granted while a load waits.
  int m_busy, m_lock, m_streak;
  bit m_cancel;

  initial begin
    int pulses;
    int ncyc;
    string got;
    string want;

    // ---------------- reset state ----------------
    idle_inputs();
    reset = 1'b1;
    bus.ld_req = 1'b1; bus.st_req = 1'b1;
    bus.dcache_addr_ok = 1'b1; bus.dcache_data_ok = 1'b1;
    @(negedge clk); #1;
    ok5("reset_outputs_quiet", 5'b00000);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    #1;
    ok5("post_reset_idle", 5'b00000);
    @(negedge clk);

    // ---------------- table: single-cycle grant decisions from reset ----------------
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 1'b0, 32'h0000_1000};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b11000, 1'b0, 32'h0000_1000};
    vt[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'b00000, 1'b0, 32'h0000_1000};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'b10100, 1'b1, 32'h0000_2000};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'b10100, 1'b1, 32'h0000_2000};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b10000, 1'b1, 32'h0000_2000};
    vt[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b10000, 1'b0, 32'h0000_1000};
    vt[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'b10100, 1'b1, 32'h0000_2000};
    for (int i = 0; i < 8; i++) begin
      reset = 1'b1; #1; reset = 1'b0;
      bus.ld_req = vt[i].ld; bus.st_req = vt[i].st;
      flush = vt[i].fl; bus.dcache_addr_ok = vt[i].aok;
      #1;
      ok5($sformatf("vec%0d_handshakes", i), vt[i].exp_ok);
      if (vt[i].exp_ok[4]) begin
        chk($sformatf("vec%0d_wr", i), bus.dcache_wr, vt[i].exp_wr);
        chk($sformatf("vec%0d_addr", i), bus.dcache_addr, vt[i].exp_addr);
        chk($sformatf("vec%0d_wstrb", i), bus.dcache_wstrb, vt[i].exp_wr ? 32'hF : 32'h0);
        chk($sformatf("vec%0d_wdata", i), bus.dcache_wdata, vt[i].exp_wr ? 32'hCAFE_F00D : 32'h0);
      end
      @(negedge clk);
    end
    do_reset();

    // ---------------- load only, data 3 cycles after addr_ok ----------------
    bus.ld_req = 1'b1; bus.dcache_addr_ok = 1'b1;
    #1;
    ok5("ld_only_addr", 5'b11000);
    chk("ld_only_wr", bus.dcache_wr, 0);
    chk("ld_only_addr_val", bus.dcache_addr, 32'h0000_1000);
    @(negedge clk);
    bus.ld_req = 1'b0; bus.dcache_addr_ok = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 3; k++) begin
      bus.dcache_data_ok = (k == 3);
      bus.dcache_rdata = (k == 3) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      ok5($sformatf("ld_only_wait%0d", k), (k == 3) ? 5'b00010 : 5'b00000);
      if (bus.ld_data_ok) begin
        pulses++;
        chk("ld_only_rdata", bus.ld_rdata, 32'hDEAD_BEEF);
      end
      @(negedge clk);
    end
    bus.dcache_data_ok = 1'b0;
    chk("ld_only_pulse_count", pulses, 1);

    // ---------------- contention with stalled addr_ok ----------------
    bus.ld_req = 1'b1; bus.st_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.dcache_addr_ok = (k == 2);
      #1;
      ok5($sformatf("cont_store_cyc%0d", k), (k == 2) ? 5'b10100 : 5'b10000);
      chk($sformatf("cont_store_wr%0d", k), bus.dcache_wr, 1);
      chk($sformatf("cont_store_addr%0d", k), bus.dcache_addr, 32'h0000_2000);
      @(negedge clk);
    end
    bus.st_req = 1'b0; bus.dcache_addr_ok = 1'b0; bus.dcache_data_ok = 1'b1;
    #1;
    ok5("cont_store_data", 5'b00001);
    @(negedge clk);
    bus.dcache_data_ok = 1'b0; bus.dcache_addr_ok = 1'b1;
    #1;
    ok5("cont_load_issue", 5'b11000);
    chk("cont_load_wr", bus.dcache_wr, 0);
    @(negedge clk);
    bus.ld_req = 1'b0; bus.dcache_addr_ok = 1'b0;
    bus.dcache_data_ok = 1'b1; bus.dcache_rdata = 32'h1234_5678;
    #1;
    ok5("cont_load_data", 5'b00010);
    chk("cont_load_rdata", bus.ld_rdata, 32'h1234_5678);
    @(negedge clk);
    bus.dcache_data_ok = 1'b0;

    // ---------------- flush in LOAD_WAIT swallows the response ----------------
    bus.ld_req = 1'b1; bus.dcache_addr_ok = 1'b1;
    #1; ok5("flw_addr", 5'b11000);
    @(negedge clk);
    bus.ld_req = 1'b0; bus.dcache_addr_ok = 1'b0; flush = 1'b1;
    #1; ok5("flw_flush", 5'b00000);
    @(negedge clk);
    flush = 1'b0;
    #1; ok5("flw_gap", 5'b00000);
    @(negedge clk);
    bus.dcache_data_ok = 1'b1;
    #1; ok5("flw_swallowed", 5'b00000);
    @(negedge clk);
    bus.dcache_data_ok = 1'b0; bus.st_req = 1'b1; bus.dcache_addr_ok = 1'b1;
    #1; ok5("flw_next_store", 5'b10100);
    @(negedge clk);
    bus.st_req = 1'b0; bus.dcache_addr_ok = 1'b0; bus.dcache_data_ok = 1'b1;
    #1; ok5("flw_store_data", 5'b00001);
    @(negedge clk);
    bus.dcache_data_ok = 1'b0;

    // ---------------- flush together with data_ok still delivers ----------------
    bus.ld_req = 1'b1; bus.dcache_addr_ok = 1'b1;
    #1; ok5("fdat_addr", 5'b11000);
    @(negedge clk);
    bus.ld_req = 1'b0; bus.dcache_addr_ok = 1'b0;
    flush = 1'b1; bus.dcache_data_ok = 1'b1; bus.dcache_rdata = 32'hAAAA_5555;
    #1; ok5("fdat_delivered", 5'b00010);
    chk("fdat_rdata", bus.ld_rdata, 32'hAAAA_5555);
    @(negedge clk);
    flush = 1'b0; bus.dcache_data_ok = 1'b0; bus.ld_req = 1'b1; bus.dcache_addr_ok = 1'b1;
    #1; ok5("fdat_next_addr", 5'b11000);
    @(negedge clk);
    bus.ld_req = 1'b0; bus.dcache_addr_ok = 1'b0; bus.dcache_data_ok = 1'b1;
    #1; ok5("fdat_next_data", 5'b00010);
    @(negedge clk);
    bus.dcache_data_ok = 1'b0;

    // ---------------- flush vs. load grant and load lock ----------------
    bus.ld_req = 1'b1; flush = 1'b1; bus.dcache_addr_ok = 1'b1;
    #1; ok5("fgrant_blocked", 5'b00000);
    @(negedge clk);
    flush = 1'b0; bus.dcache_addr_ok = 1'b0;
    #1; ok5("flock_stall", 5'b10000);
    @(negedge clk);
    flush = 1'b1; bus.dcache_addr_ok = 1'b1;
    #1; ok5("flock_released", 5'b00000);
    @(negedge clk);
    flush = 1'b0; bus.ld_req = 1'b0; bus.st_req = 1'b1;
    #1; ok5("flock_store_after", 5'b10100);
    @(negedge clk);
    bus.st_req = 1'b0; bus.dcache_addr_ok = 1'b0; bus.dcache_data_ok = 1'b1;
    #1; ok5("flock_store_data", 5'b00001);
    @(negedge clk);
    bus.dcache_data_ok = 1'b0;

    // ---------------- starvation bound ----------------
    bus.ld_req = 1'b1; bus.st_req = 1'b1;
    bus.dcache_addr_ok = 1'b1; bus.dcache_data_ok = 1'b1;
    got = ""; ncyc = 0;
    want = "SSSSLSSSSL";
    while (got.len() < want.len() && ncyc < 100) begin
      #1;
      if (bus.st_addr_ok) got = {got, "S"};
      if (bus.ld_addr_ok) got = {got, "L"};
      ncyc++;
      @(negedge clk);
    end
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL starve_grant_order: got '%s' after %0d cycles, expected '%s'", got, ncyc, want);
    end
    do_reset();

    // ---------------- async reset in STORE_WAIT ----------------
    bus.st_req = 1'b1; bus.dcache_addr_ok = 1'b1;
    #1; ok5("arst_store_addr", 5'b10100);
    @(negedge clk);
    bus.ld_req = 1'b1; bus.dcache_addr_ok = 1'b0; bus.dcache_data_ok = 1'b1;
    #1; ok5("arst_before", 5'b00001);
    reset = 1'b1;
    #1; ok5("arst_outputs_zero", 5'b00000);
    @(negedge clk);
    reset = 1'b0; bus.ld_req = 1'b0; bus.dcache_data_ok = 1'b0; bus.dcache_addr_ok = 1'b1;
    #1; ok5("arst_idle_after", 5'b10100);
    chk("arst_idle_wr", bus.dcache_wr, 1);
    @(negedge clk);
    bus.st_req = 1'b0; bus.dcache_addr_ok = 1'b0; bus.dcache_data_ok = 1'b1;
    #1; ok5("arst_store_data", 5'b00001);
    @(negedge clk);

    // ---------------- randomized traffic against the reference model ----------------
    do_reset();
    m_busy = 0; m_lock = 0; m_streak = 0; m_cancel = 1'b0;
    begin
      bit ld_done, st_done, aok, dok;
      int who;
      ld_done = 1'b0; st_done = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        if (!bus.ld_req || ld_done) begin
          bus.ld_req = ($urandom_range(0, 2) != 0);
          bus.ld_addr = $urandom; bus.ld_size = 3'($urandom_range(0, 2));
        end
        if (!bus.st_req || st_done) begin
          bus.st_req = ($urandom_range(0, 1) != 0);
          bus.st_addr = $urandom; bus.st_wdata = $urandom;
          bus.st_wstrb = 4'($urandom); bus.st_size = 3'($urandom_range(0, 2));
        end
        flush = ($urandom_range(0, 9) == 0);
        aok = ($urandom_range(0, 1) != 0);
        dok = (m_busy != 0) && ($urandom_range(0, 2) == 0);
        bus.dcache_addr_ok = aok; bus.dcache_data_ok = dok;
        bus.dcache_rdata = $urandom;
        #1;
        who = 0;
        if (m_busy == 0) begin
          if (m_lock != 0)
            who = (m_lock == 1 && flush) ? 0 : m_lock;
          else if (bus.st_req && !(m_streak == LIMIT && bus.ld_req))
            who = 2;
          else if (bus.ld_req && !flush)
            who = 1;
        end
        ok5($sformatf("rnd%0d_handshakes", cyc),
            {who != 0, who == 1 && aok, who == 2 && aok,
             m_busy == 1 && dok && !m_cancel, m_busy == 2 && dok});
        if (who == 1)
          chk($sformatf("rnd%0d_ld_payload", cyc),
              {bus.dcache_addr ^ bus.dcache_wdata, 4'b0, bus.dcache_wr, bus.dcache_size, bus.dcache_wstrb},
              {bus.ld_addr, 4'b0, 1'b0, bus.ld_size, 4'b0});
        if (who == 2)
          chk($sformatf("rnd%0d_st_payload", cyc),
              {bus.dcache_addr ^ bus.dcache_wdata, 4'b0, bus.dcache_wr, bus.dcache_size, bus.dcache_wstrb},
              {bus.st_addr ^ bus.st_wdata, 4'b0, 1'b1, bus.st_size, bus.st_wstrb});
        if (m_busy == 1 && dok && !m_cancel)
          chk($sformatf("rnd%0d_rdata", cyc), bus.ld_rdata, bus.dcache_rdata);
        ld_done = bus.ld_req && ((who == 1 && aok) || flush);
        st_done = (who == 2 && aok);
        if (!bus.ld_req || (who == 1 && aok)) m_streak = 0;
        else if (who == 2 && aok && m_streak < 15) m_streak++;
        if (m_busy == 0) m_lock = (who != 0 && !aok) ? who : 0;
        if (who != 0 && aok) begin
          m_busy = who;
          m_cancel = (who == 1) && flush;
        end else if (m_busy != 0 && dok) begin
          m_busy = 0;
          m_cancel = 1'b0;
        end else if (m_busy == 1 && flush) begin
          m_cancel = 1'b1;
        end
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

endmodule
